// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase duration timer with prescaler, sensor
// synchronizer/debouncer and one-hot lamp decode for a two-road junction.
`default_nettype none

module traffic_phase_timer #(
    parameter int TICK_DIV = 4,
    parameter int T_MAIN_G = 3,
    parameter int T_MAIN_Y = 1,
    parameter int T_SIDE_G = 2,
    parameter int T_SIDE_Y = 1,
    parameter int DEB_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state_in,
    input  logic       sensor_raw,
    output logic       timer_done,
    output logic       vehicle_present,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp
);

    typedef enum logic [1:0] {
        PH_MAIN_G = 2'b00,
        PH_MAIN_Y = 2'b01,
        PH_SIDE_Y = 2'b10,
        PH_SIDE_G = 2'b11
    } phase_e;

    localparam logic [15:0] c_PRE_MAX  = 16'(TICK_DIV - 1);
    localparam logic [7:0]  c_DEB_LEN  = 8'(DEB_LEN);
    localparam logic [7:0]  c_T_MAIN_G = 8'(T_MAIN_G);
    localparam logic [7:0]  c_T_MAIN_Y = 8'(T_MAIN_Y);
    localparam logic [7:0]  c_T_SIDE_G = 8'(T_SIDE_G);
    localparam logic [7:0]  c_T_SIDE_Y = 8'(T_SIDE_Y);

    phase_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] pre_q, pre_d;
    logic        s1_q, s2_q;
    logic [7:0]  deb_q, deb_d;
    logic        vp_q, vp_d;
    logic        w_same;
    logic        w_tick;

    function automatic logic [7:0] phase_dur(input phase_e ph);
        case (ph)
            PH_MAIN_G: phase_dur = c_T_MAIN_G;
            PH_MAIN_Y: phase_dur = c_T_MAIN_Y;
            PH_SIDE_G: phase_dur = c_T_SIDE_G;
            default:   phase_dur = c_T_SIDE_Y;
        endcase
    endfunction

    // Unregistered compare so timer_done falls in the same cycle state_in moves.
    assign w_same = (phase_e'(state_in) == state_q);
    assign w_tick = (pre_q == c_PRE_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        if (!w_same) begin
            state_d = phase_e'(state_in);
            cnt_d   = phase_dur(phase_e'(state_in));
            pre_d   = 16'd0;
        end else begin
            pre_d = w_tick ? 16'd0 : pre_q + 16'd1;
            if (w_tick && cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        deb_d = 8'd0;
        vp_d  = vp_q;
        if (s2_q != vp_q) begin
            if (deb_q + 8'd1 == c_DEB_LEN) begin
                vp_d = ~vp_q;
            end else begin
                deb_d = deb_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_MAIN_G;
            cnt_q   <= c_T_MAIN_G;
            pre_q   <= 16'd0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 8'd0;
            vp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            s1_q    <= sensor_raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            vp_q    <= vp_d;
        end
    end

    assign timer_done      = (cnt_q == 8'd0) && w_same;
    assign vehicle_present = vp_q;

    // Lamps follow the registered phase, so they trail state_in by one cycle.
    always_comb begin
        main_lamp = 3'b100;
        side_lamp = 3'b100;
        case (state_q)
            PH_MAIN_G: main_lamp = 3'b001;
            PH_MAIN_Y: main_lamp = 3'b010;
            PH_SIDE_G: side_lamp = 3'b001;
            PH_SIDE_Y: side_lamp = 3'b010;
            default: begin
                main_lamp = 3'b100;
                side_lamp = 3'b100;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
// Directed, table-driven bench for traffic_phase_timer at default parameters.
`default_nettype none

module tb_traffic_phase_timer;

    logic       clk;
    logic       rst;
    logic [1:0] state_in;
    logic       sensor_raw;
    logic       timer_done;
    logic       vehicle_present;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;

    int total = 0;
    int bad   = 0;

    traffic_phase_timer dut (
        .clk             (clk),
        .rst             (rst),
        .state_in        (state_in),
        .sensor_raw      (sensor_raw),
        .timer_done      (timer_done),
        .vehicle_present (vehicle_present),
        .main_lamp       (main_lamp),
        .side_lamp       (side_lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] st;
        logic       sens;
        int         n;
        logic       now;
        logic       td;
        logic       vp;
        logic [2:0] ml;
        logic [2:0] sl;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {state, sensor, edges, check-now, td, vp, main, side}
        tbl[0]  = '{2'b00, 1'b0, 11, 1'b0, 1'b0, 1'b0, 3'b001, 3'b100};
        tbl[1]  = '{2'b00, 1'b0,  3, 1'b0, 1'b1, 1'b0, 3'b001, 3'b100};
        tbl[2]  = '{2'b01, 1'b0,  4, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100};
        tbl[3]  = '{2'b01, 1'b0,  2, 1'b0, 1'b1, 1'b0, 3'b010, 3'b100};
        tbl[4]  = '{2'b11, 1'b0,  5, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001};
        tbl[5]  = '{2'b10, 1'b0,  4, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010};
        tbl[6]  = '{2'b10, 1'b0,  1, 1'b0, 1'b1, 1'b0, 3'b100, 3'b010};
        tbl[7]  = '{2'b00, 1'b0, 12, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100};
        tbl[8]  = '{2'b00, 1'b0,  1, 1'b0, 1'b1, 1'b0, 3'b001, 3'b100};
        tbl[9]  = '{2'b11, 1'b0,  8, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001};
        tbl[10] = '{2'b11, 1'b0,  2, 1'b0, 1'b1, 1'b0, 3'b100, 3'b001};

        rst        = 1'b1;
        state_in   = 2'b00;
        sensor_raw = 1'b0;
        repeat (2) edge1();
        chk("rst_td",   32'(timer_done),      32'h0);
        chk("rst_vp",   32'(vehicle_present), 32'h0);
        chk("rst_main", 32'(main_lamp),       32'h1);
        chk("rst_side", 32'(side_lamp),       32'h4);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            state_in   = tbl[i].st;
            sensor_raw = tbl[i].sens;
            #1;
            if (tbl[i].now) begin
                chk($sformatf("row%0d_td_now", i),   32'(timer_done), 32'h0);
                chk($sformatf("row%0d_main_lag", i), 32'(main_lamp),  32'(tbl[i-1].ml));
                chk($sformatf("row%0d_side_lag", i), 32'(side_lamp),  32'(tbl[i-1].sl));
            end
            for (int k = 1; k <= tbl[i].n; k++) begin
                edge1();
                chk($sformatf("row%0d_e%0d_td", i, k),   32'(timer_done),      32'(tbl[i].td));
                chk($sformatf("row%0d_e%0d_vp", i, k),   32'(vehicle_present), 32'(tbl[i].vp));
                chk($sformatf("row%0d_e%0d_main", i, k), 32'(main_lamp),       32'(tbl[i].ml));
                chk($sformatf("row%0d_e%0d_side", i, k), 32'(side_lamp),       32'(tbl[i].sl));
            end
        end

        // Two-cycle sensor pulse must be rejected.
        sensor_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            edge1();
            if (k == 2) sensor_raw = 1'b0;
            chk($sformatf("pulse_e%0d_vp", k), 32'(vehicle_present), 32'h0);
        end

        sensor_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edge1();
            chk($sformatf("rise_e%0d_vp", k), 32'(vehicle_present), 32'(k >= 5));
        end

        sensor_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            edge1();
            if (k == 2) sensor_raw = 1'b1;
            chk($sformatf("dropout_e%0d_vp", k), 32'(vehicle_present), 32'h1);
        end

        sensor_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            edge1();
            chk($sformatf("fall_e%0d_vp", k), 32'(vehicle_present), 32'(k < 5));
        end

        sensor_raw = 1'b1;
        state_in   = 2'b00;
        repeat (2) edge1();
        state_in = 2'b11;
        repeat (5) edge1();
        chk("pre_rst_vp",   32'(vehicle_present), 32'h1);
        chk("pre_rst_side", 32'(side_lamp),       32'h1);
        chk("pre_rst_td",   32'(timer_done),      32'h0);

        // Mid-cycle asynchronous reset.
        #3;
        rst = 1'b1;
        #1;
        chk("arst_td",   32'(timer_done),      32'h0);
        chk("arst_vp",   32'(vehicle_present), 32'h0);
        chk("arst_main", 32'(main_lamp),       32'h1);
        chk("arst_side", 32'(side_lamp),       32'h4);
        state_in   = 2'b00;
        sensor_raw = 1'b0;
        edge1();
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            edge1();
            chk($sformatf("post_rst_e%0d_td", k), 32'(timer_done),      32'(k >= 12));
            chk($sformatf("post_rst_e%0d_vp", k), 32'(vehicle_present), 32'h0);
            chk($sformatf("post_rst_e%0d_ml", k), 32'(main_lamp),       32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 Parameter TICK_DIV, 4: clk cycles per timer tick; legal range 1..65535.
REQ-002 Parameter T_MAIN_G, 3: main-green phase duration in ticks; legal range 1..255.
REQ-003 Parameter T_MAIN_Y, 1: main-yellow phase duration in ticks; legal range 1..255.
REQ-004 Parameter T_SIDE_G, 2: side-green phase duration in ticks; legal range 1..255.
REQ-005 Parameter T_SIDE_Y, 1: side-yellow phase duration in ticks; legal range 1..255.
REQ-006 Parameter DEB_LEN, 3: consecutive stable clk cycles needed to change vehicle_present; legal range 1..255.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 state_in  input  2  current controller phase: 00 main green, 01 main yellow, 11 side green, 10 side yellow.
REQ-010 sensor_raw  input  1  asynchronous side-road vehicle detector, active-high.
REQ-011 timer_done  output  1  current phase duration has expired.
REQ-012 vehicle_present  output  1  synchronized, debounced sensor level.
REQ-013 main_lamp  output  3  {red,yellow,green}, one-hot.
REQ-014 side_lamp  output  3  {red,yellow,green}, one-hot.

Function
REQ-015 The block SHALL hold a registered phase copy state_q, an 8-bit down-counter cnt and a 16-bit prescaler pre.
REQ-016 Phase change: when state_in != state_q at a rising edge, the block SHALL set state_q to state_in, load cnt with the duration for state_in, and clear pre to 0.
REQ-017 Prescaler: when there is no phase change, pre SHALL count 0..TICK_DIV-1 and wrap to 0, and a tick SHALL occur in any cycle where pre == TICK_DIV-1.
REQ-018 On a tick with cnt > 0, cnt SHALL decrement by 1; cnt SHALL saturate at 0 and never wrap.
REQ-019 A phase-change reload SHALL take precedence over a tick in the same cycle.
REQ-020 timer_done SHALL equal (cnt == 0) AND (state_in == state_q), and the comparison term SHALL be combinational so that timer_done drops in the same cycle state_in changes.
REQ-021 Latency: timer_done SHALL assert exactly T*TICK_DIV rising edges after the reload edge, where T is the phase duration.
REQ-022 timer_done SHALL then remain high until the next phase change.
REQ-023 A phase change while cnt > 0 (early exit) SHALL reload normally, and no residual count SHALL carry over.
REQ-024 Sensor sync: sensor_raw SHALL pass through a 2-flop synchronizer to give s2.
REQ-025 Debounce counter: an 8-bit counter SHALL increment each cycle that s2 != vehicle_present and SHALL clear to 0 in any cycle that s2 == vehicle_present.
REQ-026 When the debounce counter would reach DEB_LEN, vehicle_present SHALL toggle and the counter SHALL clear.
REQ-027 A pulse on s2 shorter than DEB_LEN cycles SHALL never change vehicle_present.
REQ-028 Lamps SHALL be decoded from state_q, so they lag state_in by one cycle: 00 gives main G / side R; 01 gives main Y / side R; 11 gives main R / side G; 10 gives main R / side Y.
REQ-029 All four 2-bit state codes are legal, and no output SHALL ever show more than one lamp lit per road.

Reset
REQ-030 On rst high, the block SHALL immediately force: state_q=00, cnt=T_MAIN_G, pre=0, timer_done=0, sync flops=0, debounce counter=0, vehicle_present=0, main_lamp=001, side_lamp=100.
REQ-031 Reset asserted mid-phase or mid-debounce SHALL abandon all progress, and no partial count SHALL survive deassertion.
REQ-032 After deassertion with state_in=00, timing SHALL proceed per REQ-021 from the first rising edge, treating the reset as the reload edge.

Verification (defaults TICK_DIV=4, T_MAIN_G=3, T_MAIN_Y=1, T_SIDE_G=2, T_SIDE_Y=1, DEB_LEN=3)
REQ-033 Release reset with state_in=00 held -> timer_done is low for edges 1..11 and high after edge 12, then stays high.
REQ-034 With timer_done=1, drive state_in 00->01 -> timer_done is low in that same cycle; main_lamp=010 after the next edge; timer_done is high again 4 edges after the reload edge.
REQ-035 Drive state_in=11, then after 5 edges drive 10 (early exit) -> cnt reloads to 1 and timer_done asserts 4 edges later, not earlier.
REQ-036 Pulse sensor_raw high for 2 cycles -> vehicle_present stays 0; hold sensor_raw high -> vehicle_present rises after edge 5 from the first sampling edge; a 2-cycle low dropout then does not clear it.
REQ-037 Assert rst asynchronously while state_q=11 with cnt=1 and vehicle_present=1 -> all outputs take the REQ-030 values before the next clk edge.
REQ-038 Sweep all four state_in codes -> each lamp pair matches REQ-028, with exactly one bit set per road, in every cycle.
